uart_rx_ctrl: RTL and testbench

UART_RX_CTRL -- requirements
Module: uart_rx_ctrl

---
 rtl/uart_rx_ctrl.sv | 193 +++++++++++++++++++
 tb/tb_uart_rx_ctrl.sv | 392 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_ctrl.sv
// UART receive controller: frame FSM plus edge/bit counters.
// Compile with UART_RX_PARITY_SUPPORT_EN defined to enable the parity bit.
//
// Ports:
//   CLK, RST     - clock, asynchronous active-high reset
//   RX_IN        - serial line, idle high
//   prescale     - oversampling ratio (8/16/32; values below 8 act as 8)
//   par_en       - frame carries a parity bit (latched when START ends)
//   strt_glitch  - registered start-check result
//   par_err      - registered parity-check result
//   stp_err      - registered stop-check result
//   dat_samp_en  - sampler enable, high in every state but IDLE/DONE
//   strt_chk_en  - start-check strobe
//   par_chk_en   - parity-check strobe
//   stp_chk_en   - stop-check strobe
//   deser_en     - deserializer strobe, once per data bit
//   edge_cnt     - oversample position within the current bit
//   bit_cnt      - bit index within the frame (start bit = 0)
//   data_valid   - one-cycle pulse for a clean frame
//   frame_err    - one-cycle pulse for a frame with parity/stop error
module uart_rx_ctrl (
    input  logic       CLK,
    input  logic       RST,
    input  logic       RX_IN,
    input  logic [5:0] prescale,
    input  logic       par_en,
    input  logic       strt_glitch,
    input  logic       par_err,
    input  logic       stp_err,
    output logic       dat_samp_en,
    output logic       strt_chk_en,
    output logic       par_chk_en,
    output logic       stp_chk_en,
    output logic       deser_en,
    output logic [5:0] edge_cnt,
    output logic [3:0] bit_cnt,
    output logic       data_valid,
    output logic       frame_err
);

    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] START  = 3'd1;
    localparam logic [2:0] DATA   = 3'd2;
    localparam logic [2:0] PARITY = 3'd3;
    localparam logic [2:0] STOP   = 3'd4;
    localparam logic [2:0] DONE   = 3'd5;

    logic [2:0] state_q, state_d;
    logic [5:0] edge_cnt_q, edge_cnt_d;
    logic [3:0] bit_cnt_q, bit_cnt_d;

    logic [5:0] ps;
    logic [5:0] ps_m1;
    logic [5:0] strobe_pos;
    logic       bit_last;
    logic [5:0] edge_nx;
    logic [3:0] bit_nx;
    logic       strobe;
    logic       par_use;
    logic       err_any;

    assign ps         = (prescale < 6'd8) ? 6'd8 : prescale;
    assign ps_m1      = ps - 6'd1;
    assign strobe_pos = {1'b0, ps[5:1]} + 6'd2;

    // >= rather than == so a mid-frame prescale drop cannot run away
    assign bit_last = (edge_cnt_q >= ps_m1);
    assign edge_nx  = bit_last ? 6'd0 : edge_cnt_q + 6'd1;
    assign bit_nx   = bit_last ? bit_cnt_q + 4'd1 : bit_cnt_q;
    assign strobe   = (edge_cnt_q == strobe_pos);

`ifdef UART_RX_PARITY_SUPPORT_EN
    logic par_en_q, par_en_d;

    assign par_use = par_en_q;
    assign err_any = par_err | stp_err;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            par_en_q <= 1'b0;
        end else begin
            par_en_q <= par_en_d;
        end
    end

    always_comb begin
        par_en_d = par_en_q;
        if (state_q == START && bit_last && !strt_glitch) begin
            par_en_d = par_en;
        end
    end
`else
    logic unused_par;

    assign unused_par = par_en ^ par_err;
    assign par_use    = 1'b0;
    assign err_any    = stp_err;
`endif

    always_comb begin
        state_d    = state_q;
        edge_cnt_d = edge_cnt_q;
        bit_cnt_d  = bit_cnt_q;
        unique case (state_q)
            IDLE: begin
                if (!RX_IN) begin
                    state_d    = START;
                    edge_cnt_d = 6'd0;
                    bit_cnt_d  = 4'd0;
                end
            end
            START: begin
                edge_cnt_d = edge_nx;
                bit_cnt_d  = bit_nx;
                if (bit_last) begin
                    if (strt_glitch) begin
                        state_d    = IDLE;
                        edge_cnt_d = 6'd0;
                        bit_cnt_d  = 4'd0;
                    end else begin
                        state_d = DATA;
                    end
                end
            end
            DATA: begin
                edge_cnt_d = edge_nx;
                bit_cnt_d  = bit_nx;
                if (bit_last && bit_cnt_q == 4'd8) begin
                    state_d = par_use ? PARITY : STOP;
                end
            end
            PARITY: begin
                edge_cnt_d = edge_nx;
                bit_cnt_d  = bit_nx;
                if (bit_last) begin
                    state_d = STOP;
                end
            end
            STOP: begin
                edge_cnt_d = edge_nx;
                bit_cnt_d  = bit_nx;
                if (bit_last) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                // A low line here is already the 2nd cycle of the
                // next start bit, hence edge 1.
                bit_cnt_d = 4'd0;
                if (!RX_IN) begin
                    state_d    = START;
                    edge_cnt_d = 6'd1;
                end else begin
                    state_d    = IDLE;
                    edge_cnt_d = 6'd0;
                end
            end
            default: begin
                state_d    = IDLE;
                edge_cnt_d = 6'd0;
                bit_cnt_d  = 4'd0;
            end
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q    <= IDLE;
            edge_cnt_q <= 6'd0;
            bit_cnt_q  <= 4'd0;
        end else begin
            state_q    <= state_d;
            edge_cnt_q <= edge_cnt_d;
            bit_cnt_q  <= bit_cnt_d;
        end
    end

    // Outputs decode the registered state, so reset clears them at once.
    assign dat_samp_en = (state_q != IDLE) && (state_q != DONE);
    assign strt_chk_en = (state_q == START) && strobe;
    assign deser_en    = (state_q == DATA) && strobe;
    assign stp_chk_en  = (state_q == STOP) && strobe;
`ifdef UART_RX_PARITY_SUPPORT_EN
    assign par_chk_en  = (state_q == PARITY) && strobe;
`else
    assign par_chk_en  = 1'b0;
`endif
    assign data_valid  = (state_q == DONE) && !err_any;
    assign frame_err   = (state_q == DONE) && err_any;
    assign edge_cnt    = edge_cnt_q;
    assign bit_cnt     = bit_cnt_q;

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Directed bench for uart_rx_ctrl.
// Builds with or without UART_RX_PARITY_SUPPORT_EN.
module tb_uart_rx_ctrl;

    logic       CLK = 1'b0;
    logic       RST;
    logic       RX_IN;
    logic [5:0] prescale;
    logic       par_en;
    logic       strt_glitch;
    logic       par_err;
    logic       stp_err;
    logic       dat_samp_en;
    logic       strt_chk_en;
    logic       par_chk_en;
    logic       stp_chk_en;
    logic       deser_en;
    logic [5:0] edge_cnt;
    logic [3:0] bit_cnt;
    logic       data_valid;
    logic       frame_err;

    int errors = 0;
    int checks = 0;

    int r_deser, r_strt, r_par, r_stp, r_dv, r_fe;
    int r_bad, r_samp, r_first_edge;
    int r_par_bit, r_stp_bit, r_done_samp;

    uart_rx_ctrl dut (
        .CLK        (CLK),
        .RST        (RST),
        .RX_IN      (RX_IN),
        .prescale   (prescale),
        .par_en     (par_en),
        .strt_glitch(strt_glitch),
        .par_err    (par_err),
        .stp_err    (stp_err),
        .dat_samp_en(dat_samp_en),
        .strt_chk_en(strt_chk_en),
        .par_chk_en (par_chk_en),
        .stp_chk_en (stp_chk_en),
        .deser_en   (deser_en),
        .edge_cnt   (edge_cnt),
        .bit_cnt    (bit_cnt),
        .data_valid (data_valid),
        .frame_err  (frame_err)
    );

    always #5 CLK = ~CLK;

    initial begin
        #2000000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic clear_r();
        r_deser = 0; r_strt = 0; r_par = 0; r_stp = 0;
        r_dv = 0; r_fe = 0; r_bad = 0; r_samp = 0;
        r_first_edge = -1; r_par_bit = -1; r_stp_bit = -1;
        r_done_samp = 0;
    endtask

    task automatic sample(input int exp_edge);
        if (deser_en) begin
            r_deser++;
            if (edge_cnt != exp_edge) r_bad++;
        end
        if (strt_chk_en) begin
            r_strt++;
            if (edge_cnt != exp_edge) r_bad++;
        end
        if (par_chk_en) begin
            r_par++;
            r_par_bit = bit_cnt;
            if (edge_cnt != exp_edge) r_bad++;
        end
        if (stp_chk_en) begin
            r_stp++;
            r_stp_bit = bit_cnt;
            if (edge_cnt != exp_edge) r_bad++;
        end
        if (data_valid) r_dv++;
        if (frame_err) r_fe++;
    endtask

    // Drives one frame on RX_IN, one iteration per clock.
    task automatic run_frame(
        input logic [5:0] pre,
        input logic [7:0] data,
        input bit         par,
        input bit         skip_first,
        input bit         tail_low,
        input bit         flip_par
    );
        int eff, s_idx, total, k, exp_edge;
        eff = (pre < 8) ? 8 : int'(pre);
`ifdef UART_RX_PARITY_SUPPORT_EN
        s_idx = par ? 10 : 9;
`else
        s_idx = 9;
`endif
        total = (s_idx + 1) * eff;
        exp_edge = eff / 2 + 2;
        prescale = pre;
        par_en = par;
        clear_r();
        for (int c = (skip_first ? 1 : 0); c < total; c++) begin
            k = c / eff;
            if (k == 0) RX_IN = 1'b0;
            else if (k <= 8) RX_IN = data[k-1];
            else if (k == 9 && par) RX_IN = ^data;
            else RX_IN = 1'b1;
            if (flip_par && c == 2 * eff) par_en = ~par_en;
            step();
            if (r_first_edge < 0) r_first_edge = edge_cnt;
            if (dat_samp_en) r_samp++;
            sample(exp_edge);
        end
        RX_IN = tail_low ? 1'b0 : 1'b1;
        step();
        if (dat_samp_en) r_done_samp++;
        sample(exp_edge);
        if (!tail_low) begin
            step();
            if (dat_samp_en) r_done_samp++;
            sample(exp_edge);
        end
    endtask

    task automatic test_reset();
        RST = 1'b1;
        RX_IN = 1'b1;
        prescale = 6'd8;
        par_en = 1'b0;
        strt_glitch = 1'b0;
        par_err = 1'b0;
        stp_err = 1'b0;
        step();
        step();
        checks++;
        if ({dat_samp_en, strt_chk_en, par_chk_en, stp_chk_en,
             deser_en, data_valid, frame_err} !== 7'd0) begin
            errors++;
            $display("FAIL reset_outs: got %b want 0",
                {dat_samp_en, strt_chk_en, par_chk_en,
                 stp_chk_en, deser_en, data_valid, frame_err});
        end
        checks++;
        if (edge_cnt !== 6'd0 || bit_cnt !== 4'd0) begin
            errors++;
            $display("FAIL reset_cnt: got e=%0d b=%0d want 0 0",
                edge_cnt, bit_cnt);
        end
        RST = 1'b0;
        step();
        step();
        checks++;
        if (dat_samp_en !== 1'b0) begin
            errors++;
            $display("FAIL idle_hold: samp=%b want 0", dat_samp_en);
        end
    endtask

    task automatic test_basic();
        run_frame(6'd8, 8'hA5, 1'b0, 1'b0, 1'b0, 1'b0);
        checks++;
        if (r_deser != 8 || r_bad != 0) begin
            errors++;
            $display("FAIL basic_deser: got n=%0d bad=%0d want 8 0",
                r_deser, r_bad);
        end
        checks++;
        if (r_dv != 1 || r_fe != 0) begin
            errors++;
            $display("FAIL basic_dv: got dv=%0d fe=%0d want 1 0",
                r_dv, r_fe);
        end
        checks++;
        if (r_strt != 1 || r_stp != 1 || r_stp_bit != 9) begin
            errors++;
            $display("FAIL basic_chk: strt=%0d stp=%0d bit=%0d want 1 1 9",
                r_strt, r_stp, r_stp_bit);
        end
        checks++;
        if (r_samp != 80 || r_done_samp != 0) begin
            errors++;
            $display("FAIL basic_samp: got %0d/%0d want 80/0",
                r_samp, r_done_samp);
        end
    endtask

    task automatic test_parity();
        int exp_par, exp_pbit, exp_sbit, exp_samp;
`ifdef UART_RX_PARITY_SUPPORT_EN
        exp_par = 1; exp_pbit = 9; exp_sbit = 10; exp_samp = 176;
`else
        exp_par = 0; exp_pbit = -1; exp_sbit = 9; exp_samp = 160;
`endif
        run_frame(6'd16, 8'h3C, 1'b1, 1'b0, 1'b0, 1'b0);
        checks++;
        if (r_par != exp_par || r_par_bit != exp_pbit) begin
            errors++;
            $display("FAIL par_chk: n=%0d bit=%0d want %0d %0d",
                r_par, r_par_bit, exp_par, exp_pbit);
        end
        checks++;
        if (r_stp_bit != exp_sbit || r_samp != exp_samp) begin
            errors++;
            $display("FAIL par_len: stp=%0d samp=%0d want %0d %0d",
                r_stp_bit, r_samp, exp_sbit, exp_samp);
        end
        checks++;
        if (r_dv != 1 || r_bad != 0 || r_deser != 8) begin
            errors++;
            $display("FAIL par_dv: dv=%0d bad=%0d n=%0d want 1 0 8",
                r_dv, r_bad, r_deser);
        end
    endtask

    task automatic test_par_err();
        int exp_dv, exp_fe;
`ifdef UART_RX_PARITY_SUPPORT_EN
        exp_dv = 0; exp_fe = 1;
`else
        exp_dv = 1; exp_fe = 0;
`endif
        par_err = 1'b1;
        run_frame(6'd8, 8'h01, 1'b1, 1'b0, 1'b0, 1'b0);
        par_err = 1'b0;
        checks++;
        if (r_dv != exp_dv || r_fe != exp_fe) begin
            errors++;
            $display("FAIL par_err: dv=%0d fe=%0d want %0d %0d",
                r_dv, r_fe, exp_dv, exp_fe);
        end
    endtask

    task automatic test_par_hold();
        run_frame(6'd8, 8'h0F, 1'b0, 1'b0, 1'b0, 1'b1);
        par_en = 1'b0;
        checks++;
        if (r_par != 0 || r_stp_bit != 9 || r_dv != 1) begin
            errors++;
            $display("FAIL par_hold: par=%0d stp=%0d dv=%0d want 0 9 1",
                r_par, r_stp_bit, r_dv);
        end
    endtask

    task automatic test_glitch();
        prescale = 6'd8;
        par_en = 1'b0;
        strt_glitch = 1'b1;
        clear_r();
        for (int c = 0; c < 20; c++) begin
            RX_IN = (c < 3) ? 1'b0 : 1'b1;
            step();
            sample(6);
            if (c == 7) begin
                checks++;
                if (edge_cnt !== 6'd7 || dat_samp_en !== 1'b1) begin
                    errors++;
                    $display("FAIL glitch_e7: e=%0d samp=%b want 7 1",
                        edge_cnt, dat_samp_en);
                end
            end
            if (c == 8) begin
                checks++;
                if (edge_cnt !== 6'd0 || dat_samp_en !== 1'b0) begin
                    errors++;
                    $display("FAIL glitch_idle: e=%0d samp=%b want 0 0",
                        edge_cnt, dat_samp_en);
                end
            end
        end
        strt_glitch = 1'b0;
        checks++;
        if (r_strt != 1 || r_bad != 0 || r_deser != 0 || r_dv != 0) begin
            errors++;
            $display("FAIL glitch_cnt: s=%0d b=%0d d=%0d v=%0d want 1 0 0 0",
                r_strt, r_bad, r_deser, r_dv);
        end
    endtask

    task automatic test_stop_err();
        stp_err = 1'b1;
        run_frame(6'd32, 8'h96, 1'b0, 1'b0, 1'b0, 1'b0);
        stp_err = 1'b0;
        checks++;
        if (r_fe != 1 || r_dv != 0) begin
            errors++;
            $display("FAIL stop_err: fe=%0d dv=%0d want 1 0",
                r_fe, r_dv);
        end
        checks++;
        if (r_deser != 8 || r_bad != 0 || r_samp != 320) begin
            errors++;
            $display("FAIL ps32: n=%0d bad=%0d samp=%0d want 8 0 320",
                r_deser, r_bad, r_samp);
        end
    endtask

    task automatic test_back_to_back();
        run_frame(6'd8, 8'h55, 1'b0, 1'b0, 1'b1, 1'b0);
        checks++;
        if (r_dv != 1 || r_deser != 8) begin
            errors++;
            $display("FAIL b2b_first: dv=%0d n=%0d want 1 8",
                r_dv, r_deser);
        end
        run_frame(6'd8, 8'hAA, 1'b0, 1'b1, 1'b0, 1'b0);
        checks++;
        if (r_first_edge != 1) begin
            errors++;
            $display("FAIL b2b_edge: got %0d want 1", r_first_edge);
        end
        checks++;
        if (r_dv != 1 || r_deser != 8 || r_bad != 0 || r_samp != 79) begin
            errors++;
            $display("FAIL b2b_second: dv=%0d n=%0d bad=%0d samp=%0d",
                r_dv, r_deser, r_bad, r_samp);
        end
    endtask

    task automatic test_reset_mid();
        prescale = 6'd8;
        par_en = 1'b0;
        for (int c = 0; c < 36; c++) begin
            RX_IN = (c < 8) ? 1'b0 : 1'b1;
            step();
        end
        checks++;
        if (bit_cnt !== 4'd4 || edge_cnt !== 6'd3) begin
            errors++;
            $display("FAIL mid_pos: b=%0d e=%0d want 4 3",
                bit_cnt, edge_cnt);
        end
        #3;
        RST = 1'b1;
        #1;
        checks++;
        if (edge_cnt !== 6'd0 || bit_cnt !== 4'd0 ||
            dat_samp_en !== 1'b0) begin
            errors++;
            $display("FAIL mid_rst: e=%0d b=%0d samp=%b want 0 0 0",
                edge_cnt, bit_cnt, dat_samp_en);
        end
        RX_IN = 1'b1;
        step();
        RST = 1'b0;
        step();
        run_frame(6'd8, 8'h3C, 1'b0, 1'b0, 1'b0, 1'b0);
        checks++;
        if (r_dv != 1 || r_deser != 8 || r_bad != 0) begin
            errors++;
            $display("FAIL mid_next: dv=%0d n=%0d bad=%0d want 1 8 0",
                r_dv, r_deser, r_bad);
        end
    endtask

    task automatic test_low_prescale();
        run_frame(6'd4, 8'hC3, 1'b0, 1'b0, 1'b0, 1'b0);
        checks++;
        if (r_deser != 8 || r_bad != 0 || r_samp != 80 || r_dv != 1) begin
            errors++;
            $display("FAIL ps_low: n=%0d bad=%0d samp=%0d dv=%0d",
                r_deser, r_bad, r_samp, r_dv);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_parity();
        test_par_err();
        test_par_hold();
        test_glitch();
        test_stop_err();
        test_back_to_back();
        test_reset_mid();
        test_low_prescale();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
